mod129_operand_sequencer: RTL



---
 rtl/mod129_operand_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/mod129_operand_sequencer.sv
// Byte-serial front end for the combinational modulo-129 stage: packs an operand,
// holds it steady for a settle window, then offers the captured remainder on a valid/ready port.
module mod129_operand_sequencer #(
    parameter int BYTES_PER_OP  = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic [63:0] x_out,
    input  logic [7:0]  s_in,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_data,
    output logic        res_err,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX    = 4'(BYTES_PER_OP - 1);
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [63:0] x_acc_reg, x_acc_next;
    logic [3:0]  byte_cnt_reg, byte_cnt_next;
    logic [3:0]  settle_cnt_reg, settle_cnt_next;
    logic [7:0]  res_data_reg, res_data_next;
    logic        res_err_reg, res_err_next;
    logic [15:0] op_count_reg, op_count_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= LOAD;
            x_acc_reg      <= 64'd0;
            byte_cnt_reg   <= 4'd0;
            settle_cnt_reg <= 4'd0;
            res_data_reg   <= 8'd0;
            res_err_reg    <= 1'b0;
            op_count_reg   <= 16'd0;
        end else begin
            state_reg      <= state_next;
            x_acc_reg      <= x_acc_next;
            byte_cnt_reg   <= byte_cnt_next;
            settle_cnt_reg <= settle_cnt_next;
            res_data_reg   <= res_data_next;
            res_err_reg    <= res_err_next;
            op_count_reg   <= op_count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        x_acc_next      = x_acc_reg;
        byte_cnt_next   = byte_cnt_reg;
        settle_cnt_next = settle_cnt_reg;
        res_data_next   = res_data_reg;
        res_err_next    = res_err_reg;
        op_count_next   = op_count_reg;
        in_ready        = 1'b0;
        res_valid       = 1'b0;

        case (state_reg)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    x_acc_next    = {x_acc_reg[55:0], in_data};
                    byte_cnt_next = byte_cnt_reg + 4'd1;
                    // in_last and the byte limit may coincide; either one closes the operand
                    if (in_last || (byte_cnt_reg == LAST_IDX)) begin
                        state_next      = SETTLE;
                        settle_cnt_next = SETTLE_INIT;
                    end
                end
            end
            SETTLE: begin
                if (settle_cnt_reg == 4'd0) begin
                    res_data_next = s_in;
                    res_err_next  = (s_in >= 8'd129);
                    state_next    = RESULT;
                end else begin
                    settle_cnt_next = settle_cnt_reg - 4'd1;
                end
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    op_count_next = op_count_reg + 16'd1;
                    x_acc_next    = 64'd0;
                    byte_cnt_next = 4'd0;
                    state_next    = LOAD;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    assign x_out    = x_acc_reg;
    assign res_data = res_data_reg;
    assign res_err  = res_err_reg;
    assign op_count = op_count_reg;

endmodule
